// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and sizing for the mux scan sequencer
package mux_scan_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;
endpackage

// File: rtl/mux_scan_pick.sv
// mux_scan_pick: lowest-set-bit priority encoder with an all-zero flag
module mux_scan_pick #(
  parameter int N = mux_scan_pkg::NUM_CH,
  parameter int W = mux_scan_pkg::SEL_W
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_none
);
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (i_vec[i]) o_idx = W'(i);
  end
  assign o_none = ~|i_vec;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks enabled mux channels, samples each after settling, hands the word downstream
module mux_scan_ctrl #(
  parameter int NUM_CH = mux_scan_pkg::NUM_CH,
  parameter int SEL_W = mux_scan_pkg::SEL_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  sel_o,
  input  logic              mux_in,
  output logic              busy,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [NUM_CH-1:0] data_o
);
  import mux_scan_pkg::*;
  localparam state_t RUN = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [NUM_CH-1:0] r_rem, w_rem, r_data, w_data, w_left, w_pick_in;
  logic [SEL_W-1:0] r_sel, w_sel, w_idx;
  logic r_valid, w_valid, r_busy, w_busy, w_none;
  // The encoder looks at the fresh mask while idle and at what is left after the current sample otherwise
  assign w_left = r_rem & ~(NUM_CH'(1) << r_sel);
  assign w_pick_in = (r_state == IDLE) ? mask : w_left;
  mux_scan_pick #(.N(NUM_CH), .W(SEL_W)) u_pick (
    .i_vec(w_pick_in),
    .o_idx(w_idx),
    .o_none(w_none)
  );
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_rem = r_rem;
    w_data = r_data;
    w_sel = r_sel;
    w_valid = r_valid;
    w_busy = r_busy;
    case (r_state)
      IDLE: if (start) begin
        w_busy = 1'b1;
        w_data = '0;
        w_rem = mask;
        w_valid = w_none;
        w_sel = w_none ? r_sel : w_idx;
        w_cnt = w_none ? r_cnt : LOAD;
        w_state = w_none ? HOLD : RUN;
      end
      SETTLE: begin
        w_cnt = r_cnt - CNT_W'(r_cnt != '0);
        w_state = (r_cnt == '0) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        w_data[r_sel] = mux_in;
        w_rem = w_left;
        w_valid = w_none;
        w_sel = w_none ? r_sel : w_idx;
        w_cnt = w_none ? r_cnt : LOAD;
        w_state = w_none ? HOLD : RUN;
      end
      HOLD: if (data_ready) begin
        w_valid = 1'b0;
        w_busy = 1'b0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rem <= '0;
      r_data <= '0;
      r_sel <= '0;
      r_valid <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_rem <= w_rem;
      r_data <= w_data;
      r_sel <= w_sel;
      r_valid <= w_valid;
      r_busy <= w_busy;
    end
  end
  assign sel_o = r_sel;
  assign busy = r_busy;
  assign data_valid = r_valid;
  assign data_o = r_data;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: vector table plus randomized scans against a channel-list model, for settle 1 and settle 0 builds
module tb_mux_scan_ctrl;
  logic clk = 0, rst_n = 0, st = 0, rdy = 0, cur = 0;
  logic [15:0] mk = 0, pat = 0;
  logic [3:0] sel_a, sel_b, sel;
  logic busy_a, busy_b, val_a, val_b, bsy, val;
  logic [15:0] do_a, do_b, dat;
  int n_chk = 0, n_fail = 0;

  typedef struct {logic [15:0] m, p, exp_d; logic c; int hold; bit poke; int lat;} vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(st & ~cur), .mask(mk), .sel_o(sel_a), .mux_in(pat[sel_a]),
    .busy(busy_a), .data_valid(val_a), .data_ready(rdy), .data_o(do_a)
  );
  mux_scan_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st & cur), .mask(mk), .sel_o(sel_b), .mux_in(pat[sel_b]),
    .busy(busy_b), .data_valid(val_b), .data_ready(rdy), .data_o(do_b)
  );

  assign sel = cur ? sel_b : sel_a;
  assign bsy = cur ? busy_b : busy_a;
  assign val = cur ? val_b : val_a;
  assign dat = cur ? do_b : do_a;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [15:0] m);
    int k = 0;
    for (int i = 0; i < 16; i++) k += int'(m[i]);
    return k;
  endfunction

  task automatic run_scan(input logic c, input logic [15:0] m, input logic [15:0] p, input logic [15:0] exp_d,
                          input int lat, input int hold, input bit poke);
    int idx[$];
    int s;
    logic [3:0] sel0;
    s = c ? 0 : 1;
    for (int i = 0; i < 16; i++) if (m[i]) idx.push_back(i);
    @(negedge clk);
    cur = c;
    #1;
    sel0 = sel;
    mk = m;
    pat = p;
    st = 1;
    rdy = (hold == 0);
    @(posedge clk);
    #1;
    st = 0;
    check("busy_after_start", bsy, 1);
    for (int n = 0; n < lat; n++) begin
      if (idx.size() > 0) check("sel_step", sel, idx[n / (s + 1)]);
      check("valid_early", val, 0);
      st = poke && (n == 1);
      if (poke && n == 1) mk = 16'h0001;
      @(posedge clk);
      #1;
    end
    st = 0;
    check("valid_rise", val, 1);
    check("data", dat, exp_d);
    check("sel_last", sel, (idx.size() > 0) ? idx[idx.size() - 1] : sel0);
    check("busy_hold", bsy, 1);
    for (int h = 0; h < hold; h++) begin
      st = poke && (h == 3);
      @(posedge clk);
      #1;
      check("hold_valid", val, 1);
      check("hold_data", dat, exp_d);
    end
    st = 0;
    rdy = 1;
    @(posedge clk);
    #1;
    check("valid_drop", val, 0);
    check("busy_drop", bsy, 0);
    rdy = 0;
    @(posedge clk);
    #1;
    check("no_second_scan", bsy, 0);
  endtask

  initial begin
    tbl[0] = '{16'hFFFF, 16'hA5C3, 16'hA5C3, 1'b0, 0, 1'b0, 32};
    tbl[1] = '{16'h8001, 16'hFFFF, 16'h8001, 1'b0, 0, 1'b0, 4};
    tbl[2] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 0, 1'b0, 0};
    tbl[3] = '{16'hFFFF, 16'h5A5A, 16'h5A5A, 1'b0, 20, 1'b1, 32};
    tbl[4] = '{16'hFFFF, 16'h1234, 16'h1234, 1'b1, 0, 1'b0, 16};
    tbl[5] = '{16'h0001, 16'h0001, 16'h0001, 1'b1, 2, 1'b0, 1};
    tbl[6] = '{16'h8000, 16'h0000, 16'h0000, 1'b0, 1, 1'b0, 2};
    tbl[7] = '{16'h8001, 16'h8000, 16'h8000, 1'b1, 3, 1'b1, 2};

    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", {sel_a, sel_b}, 0);
    check("rst_busy", {busy_a, busy_b}, 0);
    check("rst_valid", {val_a, val_b}, 0);
    check("rst_data", {do_a, do_b}, 0);
    @(negedge clk);
    rst_n = 1;

    for (int t = 0; t < 8; t++)
      run_scan(tbl[t].c, tbl[t].m, tbl[t].p, tbl[t].exp_d, tbl[t].lat, tbl[t].hold, tbl[t].poke);

    // Reset mid-scan must clear everything without waiting for a clock edge
    @(negedge clk);
    cur = 0;
    mk = 16'hFFFF;
    pat = 16'hFFFF;
    st = 1;
    @(posedge clk);
    #1;
    st = 0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_sel", sel_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_valid", val_a, 0);
    check("mid_rst_data", do_a, 0);
    @(negedge clk);
    rst_n = 1;
    run_scan(1'b0, 16'h0001, 16'h0001, 16'h0001, 2, 0, 1'b0);

    // Start raised on the handshake edge is taken one cycle later
    @(negedge clk);
    cur = 0;
    mk = 16'h0003;
    pat = 16'h0003;
    st = 1;
    @(posedge clk);
    #1;
    st = 0;
    for (int n = 0; n < 100 && !val; n++) begin
      @(posedge clk);
      #1;
    end
    check("hs_valid_seen", val, 1);
    check("hs_data", dat, 16'h0003);
    rdy = 1;
    st = 1;
    mk = 16'h0001;
    @(posedge clk);
    #1;
    check("hs_no_accept", bsy, 0);
    check("hs_valid_clr", val, 0);
    @(posedge clk);
    #1;
    st = 0;
    check("hs_accept_next", bsy, 1);
    for (int n = 0; n < 100 && bsy; n++) begin
      @(posedge clk);
      #1;
    end
    check("hs_drain", bsy, 0);
    check("hs_second_data", dat, 16'h0001);
    rdy = 0;

    for (int r = 0; r < 20; r++) begin
      logic [15:0] m, p;
      logic c;
      m = 16'($urandom);
      if (r % 5 == 0) m = m & 16'($urandom);
      p = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      run_scan(c, m, p, m & p, (c ? 1 : 2) * popc(m), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
